// File: rtl/adsr_envelope_if.sv
// rtl/adsr_envelope_if.sv - gate, rates, sample stream and envelope status bundle
interface adsr_envelope_if #(
   parameter int resolution_bits = 8,
   parameter int env_bits        = 8,
   parameter int rate_width      = 16
);
   logic                       gate;
   logic [resolution_bits-1:0] sample_in;
   logic [rate_width-1:0]      attack_rate;
   logic [rate_width-1:0]      decay_rate;
   logic [env_bits-1:0]        sustain_level;
   logic [rate_width-1:0]      release_rate;
   logic [resolution_bits-1:0] sample_out;
   logic [env_bits-1:0]        env_level;
   logic [2:0]                 stage;

   modport master (
      output gate, sample_in, attack_rate, decay_rate, sustain_level, release_rate,
      input  sample_out, env_level, stage
   );

   modport slave (
      input  gate, sample_in, attack_rate, decay_rate, sustain_level, release_rate,
      output sample_out, env_level, stage
   );
endinterface

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR amplitude envelope applied to an unsigned sample stream
module adsr_envelope #(
   parameter int resolution_bits = 8,
   parameter int env_bits        = 8,
   parameter int rate_width      = 16
) (
   input  logic clk,
   input  logic reset,
   adsr_envelope_if.slave bus
);
   localparam logic [env_bits-1:0] env_max = '1;
   localparam int prod_bits = resolution_bits + env_bits;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } stage_e;

   stage_e                     state_q, state_d;
   logic [env_bits-1:0]        env_q, env_d;
   logic [rate_width-1:0]      rate_cnt_q, rate_cnt_d;
   logic [resolution_bits-1:0] sample_q, sample_d;
   logic [rate_width-1:0]      active_rate;
   logic                       counting;
   logic                       tick;
   logic [prod_bits-1:0]       product;
   logic [env_bits-1:0]        prod_unused;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         env_q      <= '0;
         rate_cnt_q <= '0;
         sample_q   <= '0;
      end else begin
         state_q    <= state_d;
         env_q      <= env_d;
         rate_cnt_q <= rate_cnt_d;
         sample_q   <= sample_d;
      end
   end

   // Only the stepping stages run the prescaler; IDLE and SUSTAIN never tick.
   always_comb begin
      active_rate = '0;
      counting    = 1'b0;
      case (state_q)
         ATTACK:  begin active_rate = bus.attack_rate;  counting = 1'b1; end
         DECAY:   begin active_rate = bus.decay_rate;   counting = 1'b1; end
         RELEASE: begin active_rate = bus.release_rate; counting = 1'b1; end
         default: begin active_rate = '0;               counting = 1'b0; end
      endcase
      tick = counting && (rate_cnt_q == active_rate);
   end

   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      case (state_q)
         IDLE: begin
            if (bus.gate) state_d = ATTACK;
         end
         ATTACK: begin
            if (!bus.gate)            state_d = RELEASE;
            else if (env_q == env_max) state_d = DECAY;
            else if (tick)             env_d   = env_q + env_bits'(1);
         end
         DECAY: begin
            if (!bus.gate)                       state_d = RELEASE;
            else if (env_q <= bus.sustain_level) state_d = SUSTAIN;
            else if (tick)                        env_d   = env_q - env_bits'(1);
         end
         SUSTAIN: begin
            if (!bus.gate) state_d = RELEASE;
         end
         RELEASE: begin
            // Retrigger resumes from the current level rather than restarting at 0.
            if (bus.gate)          state_d = ATTACK;
            else if (env_q == '0)  state_d = IDLE;
            else if (tick)         env_d   = env_q - env_bits'(1);
         end
         default: begin
            state_d = IDLE;
            env_d   = '0;
         end
      endcase

      if ((state_d != state_q) || !counting || tick) rate_cnt_d = '0;
      else                                           rate_cnt_d = rate_cnt_q + rate_width'(1);
   end

   always_comb begin
      product = {{env_bits{1'b0}}, bus.sample_in} * {{resolution_bits{1'b0}}, env_q};
      {sample_d, prod_unused} = product;
   end

   assign bus.sample_out = sample_q;
   assign bus.env_level  = env_q;
   assign bus.stage      = state_q;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed self-checking bench for adsr_envelope
module tb_adsr_envelope;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   adsr_envelope_if #(.resolution_bits(8), .env_bits(8), .rate_width(16)) bus ();

   adsr_envelope #(.resolution_bits(8), .env_bits(8), .rate_width(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      bus.gate = 1'b0;
      step(1);
      reset    = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step(2);
      n_checks++;
      if (bus.stage !== 3'd0) begin n_fail++; $display("FAIL reset_stage: got %0d expected 0", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd0) begin n_fail++; $display("FAIL reset_env: got %0d expected 0", bus.env_level); end
      n_checks++;
      if (bus.sample_out !== 8'd0) begin n_fail++; $display("FAIL reset_sample: got %0d expected 0", bus.sample_out); end
      reset = 1'b1;
   endtask

   task automatic test_attack_rate3();
      do_reset();
      bus.attack_rate = 16'd3;
      bus.gate        = 1'b1;
      step(1);
      n_checks++;
      if (bus.stage !== 3'd1) begin n_fail++; $display("FAIL a3_enter: got %0d expected 1", bus.stage); end
      step(3);
      n_checks++;
      if (bus.env_level !== 8'd0) begin n_fail++; $display("FAIL a3_edge4: got %0d expected 0", bus.env_level); end
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd1) begin n_fail++; $display("FAIL a3_edge5: got %0d expected 1", bus.env_level); end
      step(3);
      n_checks++;
      if (bus.env_level !== 8'd1) begin n_fail++; $display("FAIL a3_edge8: got %0d expected 1", bus.env_level); end
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd2) begin n_fail++; $display("FAIL a3_edge9: got %0d expected 2", bus.env_level); end
   endtask

   task automatic test_full_cycle();
      do_reset();
      bus.attack_rate   = 16'd0;
      bus.decay_rate    = 16'd0;
      bus.release_rate  = 16'd1;
      bus.sustain_level = 8'd128;
      bus.sample_in     = 8'd255;
      bus.gate          = 1'b1;
      step(1);
      step(255);
      n_checks++;
      if (bus.env_level !== 8'd255) begin n_fail++; $display("FAIL fc_peak: got %0d expected 255", bus.env_level); end
      n_checks++;
      if (bus.stage !== 3'd1) begin n_fail++; $display("FAIL fc_peak_stage: got %0d expected 1", bus.stage); end
      step(1);
      n_checks++;
      if (bus.stage !== 3'd2) begin n_fail++; $display("FAIL fc_decay: got %0d expected 2", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd255) begin n_fail++; $display("FAIL fc_decay_env: got %0d expected 255", bus.env_level); end
      n_checks++;
      if (bus.sample_out !== 8'd254) begin n_fail++; $display("FAIL fc_max_product: got %0d expected 254", bus.sample_out); end
      step(127);
      n_checks++;
      if (bus.env_level !== 8'd128) begin n_fail++; $display("FAIL fc_sus_level: got %0d expected 128", bus.env_level); end
      n_checks++;
      if (bus.stage !== 3'd2) begin n_fail++; $display("FAIL fc_still_decay: got %0d expected 2", bus.stage); end
      step(1);
      n_checks++;
      if (bus.stage !== 3'd3) begin n_fail++; $display("FAIL fc_sustain: got %0d expected 3", bus.stage); end
      step(1);
      n_checks++;
      if (bus.sample_out !== 8'd127) begin n_fail++; $display("FAIL fc_sample_127: got %0d expected 127", bus.sample_out); end
      bus.sample_in = 8'd100;
      step(1);
      n_checks++;
      if (bus.sample_out !== 8'd50) begin n_fail++; $display("FAIL fc_sample_50: got %0d expected 50", bus.sample_out); end
      bus.sustain_level = 8'd10;
      step(5);
      n_checks++;
      if (bus.env_level !== 8'd128) begin n_fail++; $display("FAIL fc_sus_hold: got %0d expected 128", bus.env_level); end
      n_checks++;
      if (bus.stage !== 3'd3) begin n_fail++; $display("FAIL fc_sus_hold_stage: got %0d expected 3", bus.stage); end
   endtask

   task automatic test_release();
      bus.gate = 1'b0;
      step(1);
      n_checks++;
      if (bus.stage !== 3'd4) begin n_fail++; $display("FAIL rel_enter: got %0d expected 4", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd128) begin n_fail++; $display("FAIL rel_enter_env: got %0d expected 128", bus.env_level); end
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd128) begin n_fail++; $display("FAIL rel_first_half: got %0d expected 128", bus.env_level); end
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd127) begin n_fail++; $display("FAIL rel_first_step: got %0d expected 127", bus.env_level); end
      step(254);
      n_checks++;
      if (bus.env_level !== 8'd0) begin n_fail++; $display("FAIL rel_zero: got %0d expected 0", bus.env_level); end
      n_checks++;
      if (bus.stage !== 3'd4) begin n_fail++; $display("FAIL rel_zero_stage: got %0d expected 4", bus.stage); end
      step(1);
      n_checks++;
      if (bus.stage !== 3'd0) begin n_fail++; $display("FAIL rel_idle: got %0d expected 0", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd0) begin n_fail++; $display("FAIL rel_idle_env: got %0d expected 0", bus.env_level); end
   endtask

   task automatic test_retrigger();
      do_reset();
      bus.attack_rate  = 16'd0;
      bus.release_rate = 16'd0;
      bus.gate         = 1'b1;
      step(71);
      bus.gate = 1'b0;
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd70) begin n_fail++; $display("FAIL rt_release_env: got %0d expected 70", bus.env_level); end
      step(10);
      n_checks++;
      if (bus.env_level !== 8'd60) begin n_fail++; $display("FAIL rt_at60: got %0d expected 60", bus.env_level); end
      bus.gate = 1'b1;
      step(1);
      n_checks++;
      if (bus.stage !== 3'd1) begin n_fail++; $display("FAIL rt_stage: got %0d expected 1", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd60) begin n_fail++; $display("FAIL rt_hold: got %0d expected 60", bus.env_level); end
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd61) begin n_fail++; $display("FAIL rt_61: got %0d expected 61", bus.env_level); end
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd62) begin n_fail++; $display("FAIL rt_62: got %0d expected 62", bus.env_level); end
   endtask

   task automatic test_gate_drop_attack();
      do_reset();
      bus.attack_rate  = 16'd0;
      bus.release_rate = 16'd0;
      bus.gate         = 1'b1;
      step(41);
      n_checks++;
      if (bus.env_level !== 8'd40) begin n_fail++; $display("FAIL gd_at40: got %0d expected 40", bus.env_level); end
      bus.gate = 1'b0;
      step(1);
      n_checks++;
      if (bus.stage !== 3'd4) begin n_fail++; $display("FAIL gd_stage: got %0d expected 4", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd40) begin n_fail++; $display("FAIL gd_hold: got %0d expected 40", bus.env_level); end
      step(1);
      n_checks++;
      if (bus.env_level !== 8'd39) begin n_fail++; $display("FAIL gd_39: got %0d expected 39", bus.env_level); end
   endtask

   task automatic test_reset_mid_attack();
      do_reset();
      bus.attack_rate = 16'd0;
      bus.sample_in   = 8'd255;
      bus.gate        = 1'b1;
      step(41);
      n_checks++;
      if (bus.sample_out !== 8'd38) begin n_fail++; $display("FAIL rm_pre_sample: got %0d expected 38", bus.sample_out); end
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      n_checks++;
      if (bus.stage !== 3'd0) begin n_fail++; $display("FAIL rm_stage: got %0d expected 0", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd0) begin n_fail++; $display("FAIL rm_env: got %0d expected 0", bus.env_level); end
      n_checks++;
      if (bus.sample_out !== 8'd0) begin n_fail++; $display("FAIL rm_sample: got %0d expected 0", bus.sample_out); end
      step(1);
      n_checks++;
      if (bus.stage !== 3'd1) begin n_fail++; $display("FAIL rm_restart: got %0d expected 1", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd0) begin n_fail++; $display("FAIL rm_restart_env: got %0d expected 0", bus.env_level); end
   endtask

   task automatic test_sustain_max();
      do_reset();
      bus.attack_rate   = 16'd0;
      bus.decay_rate    = 16'd0;
      bus.sustain_level = 8'd255;
      bus.gate          = 1'b1;
      step(256);
      step(1);
      n_checks++;
      if (bus.stage !== 3'd2) begin n_fail++; $display("FAIL sm_decay: got %0d expected 2", bus.stage); end
      step(1);
      n_checks++;
      if (bus.stage !== 3'd3) begin n_fail++; $display("FAIL sm_sustain: got %0d expected 3", bus.stage); end
      n_checks++;
      if (bus.env_level !== 8'd255) begin n_fail++; $display("FAIL sm_env: got %0d expected 255", bus.env_level); end
   endtask

   initial begin
      n_checks          = 0;
      n_fail            = 0;
      reset             = 1'b0;
      bus.gate          = 1'b0;
      bus.sample_in     = 8'd0;
      bus.attack_rate   = 16'd0;
      bus.decay_rate    = 16'd0;
      bus.sustain_level = 8'd0;
      bus.release_rate  = 16'd0;
      test_reset();
      test_attack_rate3();
      test_full_cycle();
      test_release();
      test_retrigger();
      test_gate_drop_attack();
      test_reset_mid_attack();
      test_sustain_max();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
